pixel_responder: RTL and testbench
==================================

# pixel_responder

Pixel source for the decoder datapath: the sending end of the `pix_req` / `pixel_valid` pixel handshake. A host writes pixels into an internal FIFO. After `start`, the block answers each `pix_req` from the downstream consumer with one byte on `pixel_out` and a one-cycle `pixel_valid` pulse. It delivers exactly `FRAME_LEN` pixels per frame, then signals frame completion.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries of 8 bits.
- `FRAME_LEN`, 64: pixels per frame, legal range 1..65535.
- `RST_VAL`, 8'h00: reset value of `pixel_out`.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  request enable; when low, `pix_req` is ignored.
- `start`  in  1  frame start pulse.
- `wr_en`  in  1  FIFO write strobe.
- `wr_data`  in  8  pixel to write.
- `pix_req`  in  1  consumer pixel request, one pixel per asserted cycle.
- `pixel_out`  out  8  served pixel; holds its value between pulses.
- `pixel_valid`  out  1  one-cycle pulse, `pixel_out` valid.
- `full`  out  1  FIFO full.
- `level`  out  DEPTH_LOG2+1  FIFO occupancy.
- `busy`  out  1  frame in progress (state ARMED).
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.
- `underrun`  out  1  one-cycle pulse: a request arrived while the FIFO was empty.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full; cleared by `start` or `rst`.

## Operation
- States:
  - IDLE: `start` sets the pixel count to 0 and moves to ARMED.
  - ARMED: serves requests.
  - DONE: lasts one cycle, asserts `frame_done`, then returns to IDLE.
- `start` is ignored outside IDLE.
- An accepted request is `pix_req && en` in ARMED with the FIFO non-empty. It pops the FIFO head, registers the head into `pixel_out`, and increments the count.
- When the count reaches `FRAME_LEN` on an accept, the next state is DONE. No further pops occur in that frame, even if `pix_req` stays high.
- `pix_req && en` in ARMED with the FIFO empty: `underrun` pulses and nothing is popped (see Configuration).
- `pix_req` in IDLE or DONE, or with `en` low: ignored, no `underrun`.
- Writes:
  - `wr_en` with the FIFO not full pushes `wr_data`, in every state.
  - `wr_en` while full drops the data and sets `overflow`.
- Same-cycle write and pop:
  - FIFO non-empty: both happen, and `level` is unchanged.
  - FIFO empty: the write lands and no pop occurs. There is no bypass, so the request is handled as an underrun.
  - FIFO full: the pop frees a slot, so the write is accepted and `overflow` is not set.
- Pointers wrap modulo 2^DEPTH_LOG2. Full and empty are distinguished by `level`, never by pointer equality alone.
- Frame count width is 16 bits.

## Timing
- Reset values:
  - `pixel_out` = `RST_VAL`.
  - `pixel_valid`, `busy`, `frame_done`, `underrun`, `overflow`, `full` = 0.
  - `level` = 0.
  - State IDLE, FIFO emptied.
- Reset mid-frame discards the frame and all FIFO contents.
- Request to `pixel_valid` latency: 1 cycle. Request seen at edge N gives `pixel_valid` high during cycle N+1.
- Throughput: one pixel per cycle while `pix_req` is held and data is available.
- Write to pop latency: 1 cycle. A pixel written at edge N can be popped at edge N+1.
- `busy` rises the cycle after `start` is accepted and falls the cycle after the last pixel's accept.
- `frame_done` is high in the cycle after the last pixel's accept, coincident with that pixel's `pixel_valid`.
- `level` and `full` are registered and reflect all pushes and pops of the previous edge.

## Configuration
- Macro: `PIXEL_RESPONDER_HOLD_EN`.
- Defined:
  - An underrun request is latched as pending.
  - It is served at the first edge in ARMED with the FIFO non-empty and `en` high, whether or not `pix_req` is asserted then.
  - A new `pix_req` while a request is pending does not add a second pending request.
  - `underrun` still pulses once, at the request that found the FIFO empty.
  - The pending flag is cleared by `rst` or when the frame ends.
- Not defined: underrun requests are dropped, and the consumer must re-assert `pix_req`.

## Test plan
- Reset, then check every output: `pixel_out` = `RST_VAL`, all flags 0, `level` = 0.
- FRAME_LEN=4, write 8'h11, 22, 33, 44, 55, `start`, hold `pix_req` for 6 cycles:
  - `pixel_valid` on 4 consecutive cycles with values 11, 22, 33, 44;
  - `frame_done` coincident with 44;
  - `level` ends at 1 (8'h55 remains).
- Write 2^DEPTH_LOG2 + 1 pixels with no reads: `full` = 1, `overflow` = 1, `level` = 16. Then `start` clears `overflow`.
- `start` with FIFO empty, one-cycle `pix_req`:
  - `underrun` pulses;
  - write 8'hA5 next cycle;
  - without the macro, no `pixel_valid` until `pix_req` is re-asserted;
  - with the macro, `pixel_valid` with 8'hA5 one cycle after the write edge.
- Assert `rst` mid-frame after 2 of 4 pixels: `busy` = 0 and `level` = 0 next cycle. A new frame after reset starts from count 0.

Source files
------------

// File: rtl/pixel_responder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_responder
// Purpose  : FIFO-backed pixel source. Answers pix_req with one byte and a
//            pixel_valid pulse, delivering FRAME_LEN pixels per frame.
// Option   : PIXEL_RESPONDER_HOLD_EN - latch an underrun request and serve
//            it once data arrives.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_responder #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          FRAME_LEN  = 64,
  parameter logic [7:0]  RST_VAL    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  pix_req,
  output logic [7:0]            pixel_out,
  output logic                  pixel_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  overflow
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]         FRAME_LAST = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic [7:0]            pixel_out_q, pixel_out_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            mem_q [DEPTH];

  logic empty;
  logic req;
  logic pop;
  logic push;
  logic drop;
  logic start_acc;

`ifdef PIXEL_RESPONDER_HOLD_EN
  logic pend_q, pend_d;
`endif

  // Request qualification and FIFO handshake
  always_comb begin
    empty     = (level_q == '0);
    req       = pix_req && en && (state_q == ST_ARMED);
    start_acc = start && (state_q == ST_IDLE);
`ifdef PIXEL_RESPONDER_HOLD_EN
    pop        = (state_q == ST_ARMED) && en && !empty && (pix_req || pend_q);
    underrun_d = req && empty && !pend_q;
    pend_d     = pend_q;
    if (req && empty) begin
      pend_d = 1'b1;
    end
    if (pop || (state_q != ST_ARMED)) begin
      pend_d = 1'b0;
    end
`else
    pop        = req && !empty;
    underrun_d = req && empty;
`endif
    // A pop in the same cycle frees a slot, so a write at full still lands
    push = wr_en && (!full_q || pop);
    drop = wr_en && full_q && !pop;
  end

  // FIFO bookkeeping and output data
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    overflow_d    = overflow_q;
    pixel_out_d   = pixel_out_q;
    pixel_valid_d = pop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      pixel_out_d = mem_q[rd_ptr_q];
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    if (start_acc) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    full_d = (level_d == LVL_FULL);
  end

  // Frame state machine
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (pop) begin
          count_d = count_q + 1'b1;
          if (count_q == FRAME_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      pixel_out_q   <= RST_VAL;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef PIXEL_RESPONDER_HOLD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  // Storage needs no reset: pointers and level define its contents
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign pixel_out   = pixel_out_q;
  assign pixel_valid = pixel_valid_q;
  assign full        = full_q;
  assign level       = level_q;
  assign busy        = (state_q == ST_ARMED);
  assign frame_done  = (state_q == ST_DONE);
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_responder
// Purpose  : Directed scoreboard bench for pixel_responder (FRAME_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_responder;

  localparam int DL2 = 4;

  logic         clk = 1'b0;
  logic         rst, en, start, wr_en, pix_req;
  logic [7:0]   wr_data;
  logic [7:0]   pixel_out;
  logic         pixel_valid, full, busy, frame_done, underrun, overflow;
  logic [DL2:0] level;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int done_cnt  = 0;
  int first_v   = -1;
  int last_v    = -1;
  logic [7:0] exp_q [$];

  pixel_responder #(
    .DEPTH_LOG2 (DL2),
    .FRAME_LEN  (4),
    .RST_VAL    (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .pix_req     (pix_req),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .full        (full),
    .level       (level),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Scoreboard: each pixel_valid consumes the oldest expected pixel
  always @(negedge clk) begin
    cyc++;
    if (!rst && pixel_valid) begin
      valid_cnt++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("pixel", {24'd0, pixel_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!rst && frame_done) begin
      done_cnt++;
      check("done_with_valid", {31'd0, pixel_valid}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    int d0;
    rst = 1'b1; en = 1'b1; start = 1'b0; wr_en = 1'b0; wr_data = 8'h00; pix_req = 1'b0;
    tick(2);

    // Reset values
    check("rst_pixel_out", {24'd0, pixel_out}, 32'h00);
    check("rst_flags", {26'd0, pixel_valid, busy, frame_done, underrun, overflow, full}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame: 5 writes, 4 served, one left over
    write_px(8'h11); write_px(8'h22); write_px(8'h33); write_px(8'h44); write_px(8'h55);
    check("level_after_writes", {27'd0, level}, 32'd5);
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    first_v = -1; last_v = -1;
    pix_req = 1'b1; tick(6); pix_req = 1'b0;
    tick();
    check("frame_valids", valid_cnt, 32'd4);
    check("frame_consecutive", last_v - first_v, 32'd3);
    check("frame_done_cnt", done_cnt, 32'd1);
    check("frame_sb_empty", exp_q.size(), 32'd0);
    check("frame_level_left", {27'd0, level}, 32'd1);
    check("frame_busy_low", {31'd0, busy}, 32'd0);

    // Overflow: 17 writes into an empty 16-deep FIFO
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 17; i++) write_px(8'h80 + 8'(i));
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_level", {27'd0, level}, 32'd16);
    start = 1'b1; tick(); start = 1'b0;
    check("ovf_cleared_by_start", {31'd0, overflow}, 32'd0);

    // Write while full coincident with a pop is accepted
    exp_q.push_back(8'h80); exp_q.push_back(8'h81);
    exp_q.push_back(8'h82); exp_q.push_back(8'h83);
    pix_req = 1'b1; wr_en = 1'b1; wr_data = 8'hF0;
    tick();
    wr_en = 1'b0;
    check("full_pop_write_level", {27'd0, level}, 32'd16);
    check("full_pop_write_no_ovf", {31'd0, overflow}, 32'd0);
    tick(3); pix_req = 1'b0;
    tick(2);
    check("full_frame_sb_empty", exp_q.size(), 32'd0);
    check("full_frame_level", {27'd0, level}, 32'd13);

    // Underrun with an empty FIFO
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    v0 = valid_cnt;
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    check("underrun_pulse", {31'd0, underrun}, 32'd1);
    wr_en = 1'b1; wr_data = 8'hA5; tick(); wr_en = 1'b0;
    check("underrun_one_cycle", {31'd0, underrun}, 32'd0);
    check("no_valid_at_write", {31'd0, pixel_valid}, 32'd0);
`ifdef PIXEL_RESPONDER_HOLD_EN
    exp_q.push_back(8'hA5);
    tick();
    check("pending_served", {31'd0, pixel_valid}, 32'd1);
    check("pending_no_underrun", {31'd0, underrun}, 32'd0);
`else
    tick(3);
    check("no_valid_without_req", valid_cnt - v0, 32'd0);
    exp_q.push_back(8'hA5);
    pix_req = 1'b1; tick(); pix_req = 1'b0;
    check("reassert_served", {31'd0, pixel_valid}, 32'd1);
`endif
    tick();
    check("underrun_sb_empty", exp_q.size(), 32'd0);

    // Reset mid-frame, then a fresh frame counts from zero
    rst = 1'b1; tick(); rst = 1'b0;
    write_px(8'h01); write_px(8'h02); write_px(8'h03); write_px(8'h04);
    start = 1'b1; tick(); start = 1'b0;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    pix_req = 1'b1; tick(2); pix_req = 1'b0;
    tick();
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_level", {27'd0, level}, 32'd0);
    d0 = done_cnt;
    write_px(8'hC1); write_px(8'hC2); write_px(8'hC3); write_px(8'hC4);
    start = 1'b1; tick(); start = 1'b0;
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
    pix_req = 1'b1; tick(4); pix_req = 1'b0;
    tick(2);
    check("refresh_frame_done", done_cnt - d0, 32'd1);
    check("refresh_sb_empty", exp_q.size(), 32'd0);
    check("refresh_level", {27'd0, level}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
